sign_cmp_pipe: RTL and testbench

Parametrised, pipelined magnitude comparator for two WIDTH-bit operands. It supports both signed (two's-complement) and unsigned modes, selectable per sample. Operand pairs enter through a valid/ready handshake. After two pipeline stages the block produces registered AGEB/AGTB/AEQB flags. It sits between sample sources and threshold/decision logic and replaces single-shot 8-bit combinational signed compares in streaming datapaths.

---
 rtl/sign_cmp_pipe.sv | 121 ++++++++++++
 tb/tb_sign_cmp_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module     : sign_cmp_pipe
// Description: Two-stage pipelined magnitude comparator for WIDTH-bit
//              operands, signed or unsigned per sample, with valid/ready
//              handshake. Produces registered AGEB/AGTB/AEQB flags.
//              Optional running-maximum tracker of accepted DataA, built
//              when the macro SIGN_CMP_TRACK_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
module sign_cmp_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             AGEB,
  output logic             AGTB,
  output logic             AEQB,
  input  logic             CLR,
  output logic [WIDTH-1:0] MAXA,
  output logic             MAX_VALID
);

  // Pipeline control: everything moves unless a result is waiting to be taken.
  logic w_adv;
  logic w_accept;

  // Operands extended by one bit so signed and unsigned share one subtractor.
  logic [WIDTH:0]   w_aExt;
  logic [WIDTH:0]   w_bExt;
  // One further bit of headroom keeps the difference from wrapping.
  logic [WIDTH+1:0] w_diff;

  logic [WIDTH+1:0] r_s1Diff;
  logic             r_s1Valid;
  logic             w_s1Ge;
  logic             w_s1Eq;

  assign w_adv    = !OUT_VALID || OUT_READY;
  assign IN_READY = w_adv;
  assign w_accept = IN_VALID && w_adv;

  assign w_aExt = {MODE & DataA[WIDTH-1], DataA};
  assign w_bExt = {MODE & DataB[WIDTH-1], DataB};
  assign w_diff = {w_aExt[WIDTH], w_aExt} - {w_bExt[WIDTH], w_bExt};

  assign w_s1Ge = ~r_s1Diff[WIDTH+1];
  assign w_s1Eq = (r_s1Diff == '0);

  // Stage 1: register the extended difference and the accept marker.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1Diff  <= '0;
      r_s1Valid <= 1'b0;
    end else if (w_adv) begin
      r_s1Diff  <= w_diff;
      r_s1Valid <= w_accept;
    end
  end

  // Stage 2: decode flags; they are forced low for bubbles so idle outputs read zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      AGEB      <= 1'b0;
      AGTB      <= 1'b0;
      AEQB      <= 1'b0;
    end else if (w_adv) begin
      OUT_VALID <= r_s1Valid;
      AGEB      <= r_s1Valid & w_s1Ge;
      AGTB      <= r_s1Valid & w_s1Ge & ~w_s1Eq;
      AEQB      <= r_s1Valid & w_s1Eq;
    end
  end

`ifdef SIGN_CMP_TRACK_EN
  // Running maximum of accepted DataA, compared in the sample's own mode.
  logic [WIDTH:0] w_maxExt;
  logic           w_aGtMax;

  assign w_maxExt = {MODE & MAXA[WIDTH-1], MAXA};
  assign w_aGtMax = $signed(w_aExt) > $signed(w_maxExt);

  // Tracker update: CLR restarts history, taking the concurrent sample if any.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MAXA      <= '0;
      MAX_VALID <= 1'b0;
    end else if (CLR) begin
      if (w_accept) begin
        MAXA      <= DataA;
        MAX_VALID <= 1'b1;
      end else begin
        MAXA      <= '0;
        MAX_VALID <= 1'b0;
      end
    end else if (w_accept) begin
      if (!MAX_VALID || w_aGtMax) begin
        MAXA <= DataA;
      end
      MAX_VALID <= 1'b1;
    end
  end
`else
  // Tracker absent: CLR has no effect and the tracker outputs are constant.
  logic w_unusedClr;

  assign w_unusedClr = CLR;
  assign MAXA        = '0;
  assign MAX_VALID   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sign_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module     : tb_sign_cmp_pipe
// Description: Self-checking bench for sign_cmp_pipe (WIDTH=8): vector table,
//              stall/drain, random stream, mid-flight reset, tracker checks.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_sign_cmp_pipe;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] DataA;
  logic [W-1:0] DataB;
  logic         MODE;
  logic         IN_VALID;
  logic         IN_READY;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         AGEB;
  logic         AGTB;
  logic         AEQB;
  logic         CLR;
  logic [W-1:0] MAXA;
  logic         MAX_VALID;

  sign_cmp_pipe #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DataA     (DataA),
    .DataB     (DataB),
    .MODE      (MODE),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .AGEB      (AGEB),
    .AGTB      (AGTB),
    .AEQB      (AEQB),
    .CLR       (CLR),
    .MAXA      (MAXA),
    .MAX_VALID (MAX_VALID)
  );

  always #5 CLK = ~CLK;

  // Expected flags are packed as {AGEB, AGTB, AEQB}.
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [2:0]   exp;
  } vec_t;

  vec_t       tbl[12];
  logic [2:0] sbQ[$];
  int         nCompared = 0;
  int         nMismatch = 0;
  int         nPushed   = 0;
  int         nPopped   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: interpret operands as integers and compare.
  function automatic logic [2:0] refCmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    if (m && a[W-1]) av = av - (1 << W);
    if (m && b[W-1]) bv = bv - (1 << W);
    return {av >= bv, av > bv, av == bv};
  endfunction

  // Drive one pair, wait for acceptance, push its expected flags.
  task automatic sendPair(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input logic [2:0] exp, output int waits);
    bit done;
    done     = 1'b0;
    waits    = 0;
    DataA    = a;
    DataB    = b;
    MODE     = m;
    IN_VALID = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        sbQ.push_back(exp);
        nPushed++;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    if (!done) begin
      nCompared++;
      nMismatch++;
      $display("FAIL accept_timeout: got IN_READY=0 for 64 cycles, expected acceptance");
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sbQ.size() != 0 && k < 100) begin
      @(posedge CLK);
      #1;
      k++;
    end
    check(name, sbQ.size(), 0);
  endtask

  // Scoreboard: pop and compare on every output handshake.
  always @(negedge CLK) begin
    if (RESET) begin
      sbQ.delete();
    end else if (OUT_VALID && OUT_READY) begin
      if (sbQ.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("FAIL unexpected_result: got flags %b with empty scoreboard, expected no output",
                 {AGEB, AGTB, AEQB});
      end else begin
        nPopped++;
        check("result_flags", {29'd0, AGEB, AGTB, AEQB}, {29'd0, sbQ.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w;
    int           totalWaits;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rm;
    logic [W-1:0] trkA[4];
    logic [W-1:0] trkExp[4];
    logic         trkVal;

    tbl[0]  = '{8'h80, 8'h7F, 1'b1, 3'b000};
    tbl[1]  = '{8'h80, 8'h7F, 1'b0, 3'b110};
    tbl[2]  = '{8'hFF, 8'hFF, 1'b1, 3'b101};
    tbl[3]  = '{8'h00, 8'hFF, 1'b1, 3'b110};
    tbl[4]  = '{8'h00, 8'hFF, 1'b0, 3'b000};
    tbl[5]  = '{8'h7F, 8'h80, 1'b1, 3'b110};
    tbl[6]  = '{8'h80, 8'h80, 1'b0, 3'b101};
    tbl[7]  = '{8'h01, 8'h02, 1'b0, 3'b000};
    tbl[8]  = '{8'hFE, 8'hFF, 1'b1, 3'b000};
    tbl[9]  = '{8'hFF, 8'hFE, 1'b0, 3'b110};
    tbl[10] = '{8'h80, 8'h01, 1'b1, 3'b000};
    tbl[11] = '{8'h55, 8'h55, 1'b0, 3'b101};

    trkA = '{8'h10, 8'hF0, 8'h7F, 8'h80};
`ifdef SIGN_CMP_TRACK_EN
    trkExp = '{8'h10, 8'h10, 8'h7F, 8'h7F};
    trkVal = 1'b1;
`else
    trkExp = '{8'h00, 8'h00, 8'h00, 8'h00};
    trkVal = 1'b0;
`endif

    RESET     = 1'b1;
    DataA     = '0;
    DataB     = '0;
    MODE      = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    CLR       = 1'b0;
    #12;
    check("reset_outputs", {28'd0, OUT_VALID, AGEB, AGTB, AEQB}, 0);
    check("reset_in_ready", IN_READY, 1);
    check("reset_maxa", {23'd0, MAX_VALID, MAXA}, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Latency: one pair, result visible two edges after being presented.
    sendPair(8'h80, 8'h7F, 1'b1, 3'b000, w);
    check("latency_s1_only", OUT_VALID, 0);
    @(posedge CLK);
    #1;
    check("latency_out_valid", OUT_VALID, 1);
    drain("drain_latency");

    // Vector table, back to back.
    for (int i = 0; i < 12; i++) begin
      sendPair(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].exp, w);
    end
    drain("drain_table");

    // Stall: downstream not ready; first result must hold and input must block.
    OUT_READY = 1'b0;
    fork
      begin
        sendPair(8'h7F, 8'h80, 1'b1, 3'b110, w);
        sendPair(8'h10, 8'h10, 1'b0, 3'b101, w);
        sendPair(8'h80, 8'h7F, 1'b1, 3'b000, w);
        sendPair(8'hF0, 8'h0F, 1'b0, 3'b110, w);
      end
      begin
        int k;
        k = 0;
        while (!OUT_VALID && k < 20) begin
          @(negedge CLK);
          k++;
        end
        check("stall_first_result", OUT_VALID, 1);
        for (int c = 0; c < 5; c++) begin
          @(negedge CLK);
          check("stall_in_ready", IN_READY, 0);
          check("stall_hold", {28'd0, OUT_VALID, AGEB, AGTB, AEQB}, 32'b1110);
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
      end
    join
    drain("drain_stall");
    check("no_loss_or_dup", nPopped, nPushed);

    // Random back-to-back stream, mixed modes, must never wait.
    totalWaits = 0;
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom_range(0, 1));
      sendPair(ra, rb, rm, refCmp(ra, rb, rm), w);
      totalWaits += w;
    end
    check("stream_no_stall", totalWaits, 0);
    drain("drain_random");

    // Reset with two pairs in flight: outputs clear at once, nothing stale after.
    sendPair(8'h7F, 8'h00, 1'b1, 3'b110, w);
    sendPair(8'h00, 8'h00, 1'b1, 3'b101, w);
    RESET = 1'b1;
    #1;
    check("midreset_outputs", {28'd0, OUT_VALID, AGEB, AGTB, AEQB}, 0);
    check("midreset_in_ready", IN_READY, 1);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("midreset_no_stale", OUT_VALID, 0);
    check("midreset_maxvalid", MAX_VALID, 0);

    // Normal latency after reset release.
    sendPair(8'h02, 8'h01, 1'b0, 3'b110, w);
    @(posedge CLK);
    #1;
    check("post_reset_latency", OUT_VALID, 1);
    drain("drain_post_reset");

    // Tracker sequence (tied to zero when the tracker is not built).
    for (int i = 0; i < 4; i++) begin
      sendPair(trkA[i], 8'h00, 1'b1, refCmp(trkA[i], 8'h00, 1'b1), w);
      check("trk_maxa", MAXA, trkExp[i]);
      check("trk_valid", MAX_VALID, trkVal);
    end
    CLR = 1'b1;
    sendPair(8'h85, 8'h85, 1'b1, 3'b101, w);
    CLR = 1'b0;
    check("trk_clr_accept", {23'd0, MAX_VALID, MAXA}, trkVal ? 32'h185 : 32'h0);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    check("trk_clr_alone", {23'd0, MAX_VALID, MAXA}, 0);
    drain("drain_tracker");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
`default_nettype wire
